// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - CDB field layout, FU tags and requester index constants
package cdb_arbiter_pkg;

  // CDB word layout, MSB first: {on, fu_tag, rs_onehot, result}
  localparam int CDB_DATA_W   = 32;
  localparam int CDB_RS_W     = 8;
  localparam int CDB_FU_W     = 3;
  localparam int NUM_CDBBITS  = 1 + CDB_FU_W + CDB_RS_W + CDB_DATA_W;

  localparam int CDB_ON_FIELD = NUM_CDBBITS - 1;
  localparam int CDB_FU_LSB   = CDB_RS_W + CDB_DATA_W;
  localparam int CDB_RS_LSB   = CDB_DATA_W;

  typedef enum logic [CDB_FU_W-1:0] {
    FU_NONE_TAG = 3'd0,
    FU_ALU_TAG  = 3'd1,
    FU_LS_TAG   = 3'd2,
    FU_MUL_TAG  = 3'd3,
    FU_DIV_TAG  = 3'd4,
    FU_JUMP_TAG = 3'd5
  } fu_tag_e;

  // Fixed mapping of arbiter port index to functional unit
  localparam int CDB_REQ_ALU  = 0;
  localparam int CDB_REQ_LS   = 1;
  localparam int CDB_REQ_MUL  = 2;
  localparam int CDB_REQ_DIV  = 3;
  localparam int CDB_REQ_JUMP = 4;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester/CDB bundle between functional units and the arbiter
import cdb_arbiter_pkg::*;

interface cdb_arbiter_if #(
  parameter int NUM_REQ   = 5,
  parameter int PAYLOAD_W = NUM_CDBBITS - 1
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*PAYLOAD_W-1:0] payload;
  logic [NUM_REQ-1:0]           grant;
  logic [PAYLOAD_W:0]           cdb;
  logic [NUM_REQ-1:0]           last_grant;

  // Functional-unit side
  modport master (output req, payload, input grant, cdb, last_grant);
  // Arbiter side
  modport slave  (input req, payload, output grant, cdb, last_grant);
endinterface

// File: rtl/cdb_arbiter_rr_priority_pick.sv
// rtl/cdb_arbiter_rr_priority_pick.sv - rotate / priority-encode / unrotate round-robin picker
module rr_priority_pick #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rotated;
  logic [N-1:0]   rot_oh;
  logic [2*N-1:0] unrot;

  // Rotate so bit 0 is the pointer position, keep the lowest set bit, rotate back
  always_comb begin
    dbl     = {elig, elig} >> ptr;
    rotated = dbl[N-1:0];
    rot_oh  = rotated & (~rotated + N'(1));
    unrot   = {rot_oh, rot_oh} << ptr;
    grant   = unrot[2*N-1:N];
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter; optional CDB_PERF_CNT_EN perf counters
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int PAYLOAD_W = NUM_CDBBITS - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]   perf_busy_cnt,
  output logic [31:0]   perf_conflict_cnt
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]        ptr;
  logic [PW-1:0]        ptr_next;
  logic [PW-1:0]        g_idx;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   pick;
  logic [NUM_REQ-1:0]   grant_c;
  logic [NUM_REQ-1:0]   last_grant_q;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [PAYLOAD_W:0]   cdb_q;

  // The unit broadcast last cycle sits out one edge so a late-dropping request is not sent twice
  assign elig = bus.req & ~last_grant_q;

  rr_priority_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .grant (pick)
  );

  // Flushed results are dropped rather than broadcast
  assign grant_c = flush ? '0 : pick;

  // Select the granted payload and encode its index for the pointer update
  always_comb begin
    sel_payload = '0;
    g_idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_c[i]) begin
        sel_payload = bus.payload[i*PAYLOAD_W +: PAYLOAD_W];
        g_idx       = PW'(i);
      end
    end
    ptr_next = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
  end

  // Registered CDB: one-cycle broadcast of the winner, otherwise an all-zero idle bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_q        <= '0;
      last_grant_q <= '0;
      ptr          <= '0;
    end else if (|grant_c) begin
      cdb_q        <= {1'b1, sel_payload};
      last_grant_q <= grant_c;
      ptr          <= ptr_next;
    end else begin
      cdb_q        <= '0;
      last_grant_q <= '0;
    end
  end

  assign bus.grant      = grant_c;
  assign bus.cdb        = cdb_q;
  assign bus.last_grant = last_grant_q;

`ifdef CDB_PERF_CNT_EN
  // Busy counts cycles the bus carries a result; conflict counts cycles with contention
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_cnt     <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (cdb_q[PAYLOAD_W])
        perf_busy_cnt <= perf_busy_cnt + 32'd1;
      if ($countones(elig) >= 2)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
